regfile_nr1w: RTL and testbench

Parametrised register file with N read ports and one write port for the datapath. It generalises the fixed 5-to-32 enabled write-select decoder into a complete storage block: address width, data width and read-port count are set by parameter. An optional hard-wired zero register and optional write-to-read bypass are also provided. It sits between instruction decode (register addresses) and the ALU/writeback stage.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/decoder_n.sv | 12 +
 rtl/regfile_nr1w.sv | 71 +++++++
 tb/tb_regfile_nr1w.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, types and helpers for the N-read/1-write register file.
package regfile_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 64;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    // Index of the hard-wired zero register for a given address width.
    function automatic int rf_zero_idx(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/decoder_n.sv
// decoder_n: N-to-2^N one-hot decoder with enable; all outputs low when en is low.
module decoder_n #(
    parameter int N = 5
) (
    input  logic          en,
    input  logic [N-1:0]  sel,
    output logic [2**N-1:0] dec
);

    always_comb dec = {{(2**N-1){1'b0}}, en} << sel;

endmodule

// File: rtl/regfile_nr1w.sv
// regfile_nr1w: register file with NUM_RD combinational read ports and one write port,
// optional hard-wired zero register (index NREG-1) and optional write-to-read bypass.
module regfile_nr1w
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     wr_ack
);

    localparam int NREG = 2**ADDR_W;
    localparam int ZIDX = rf_zero_idx(ADDR_W);
    localparam logic [NREG-1:0] ZMASK = (ZERO_REG != 0) ? (NREG'(1) << ZIDX) : '0;

    logic [NREG-1:0]   we;
    logic [NREG-1:0]   we_ok;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_ack_q, wr_ack_d;
    logic              byp_en;

    decoder_n #(.N(ADDR_W)) u_dec (
        .en  (wr_en),
        .sel (wr_addr),
        .dec (we)
    );

    // Writes to the zero register are dropped here, so they neither store nor ack.
    assign we_ok = we & ~ZMASK;

    always_comb begin
        for (int i = 0; i < NREG; i++)
            regs_d[i] = we_ok[i] ? wr_data : regs_q[i];
        wr_ack_d = |we_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q   <= '{default: '0};
            wr_ack_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign wr_ack = wr_ack_q;

    // Bypass is suppressed during reset so every read shows 0 while reset is held.
    assign byp_en = (BYPASS != 0) && reset_n && wr_en;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        assign ra = rd_addr[p*ADDR_W +: ADDR_W];
        always_comb rd = ZMASK[ra] ? '0 : (byp_en && ra == wr_addr) ? wr_data : regs_q[ra];
        assign rd_data[p*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_nr1w.sv
// tb_regfile_nr1w: directed checks of the default configuration, a no-bypass twin,
// and a small 8x16 three-port variant without zero register.
module tb_regfile_nr1w;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic [9:0]   rd_addr = '0;
    logic [127:0] rd_data_a, rd_data_b;
    logic         ack_a, ack_b;

    logic         v_wr_en = 1'b0;
    logic [2:0]   v_wr_addr = '0;
    logic [15:0]  v_wr_data = '0;
    logic [8:0]   v_rd_addr = '0;
    logic [47:0]  v_rd_data;
    logic         v_ack;

    int total = 0;
    int bad = 0;

    wire [63:0] a0 = rd_data_a[63:0];
    wire [63:0] a1 = rd_data_a[127:64];
    wire [63:0] b0 = rd_data_b[63:0];
    wire [63:0] b1 = rd_data_b[127:64];

    always #5 clk = ~clk;

    regfile_nr1w u_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .wr_ack(ack_a)
    );

    regfile_nr1w #(.BYPASS(0)) u_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .wr_ack(ack_b)
    );

    regfile_nr1w #(.ADDR_W(3), .DATA_W(16), .NUM_RD(3), .ZERO_REG(0)) u_v (
        .clk(clk), .reset_n(reset_n), .wr_en(v_wr_en), .wr_addr(v_wr_addr), .wr_data(v_wr_data),
        .rd_addr(v_rd_addr), .rd_data(v_rd_data), .wr_ack(v_ack)
    );

    task automatic test_reset();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD; rd_addr = {5'd0, 5'd3};
        #1;
        total++; if (a0 !== 64'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", a0); end
        total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack_a); end
        @(negedge clk); #1;
        total++; if (a0 !== 64'h0) begin bad++; $display("FAIL rst_rd_edge got=%h exp=0", a0); end
        total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL rst_ack_edge got=%b exp=0", ack_a); end
        reset_n = 1'b1;
        #1;
        total++; if (a0 !== 64'hDEAD) begin bad++; $display("FAIL rel_bypass got=%h exp=dead", a0); end
        total++; if (b0 !== 64'h0) begin bad++; $display("FAIL rel_nobyp got=%h exp=0", b0); end
        @(negedge clk); wr_en = 1'b0; #1;
        total++; if (a0 !== 64'hDEAD) begin bad++; $display("FAIL rel_commit got=%h exp=dead", a0); end
        total++; if (b0 !== 64'hDEAD) begin bad++; $display("FAIL rel_commit_b got=%h exp=dead", b0); end
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL rel_ack got=%b exp=1", ack_a); end
        @(negedge clk); #1;
        total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL rel_ack_drop got=%b exp=0", ack_a); end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i) * 64'h0101_0101;
        end
        @(negedge clk); wr_en = 1'b0;
        #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL sweep_ack got=%b exp=1", ack_a); end
        for (int i = 0; i < 31; i++) begin
            rd_addr = {5'(30 - i), 5'(i)};
            #1;
            total++;
            if (a0 !== 64'(i) * 64'h0101_0101) begin
                bad++; $display("FAIL sweep_p0 reg=%0d got=%h exp=%h", i, a0, 64'(i) * 64'h0101_0101);
            end
            total++;
            if (a1 !== 64'(30 - i) * 64'h0101_0101) begin
                bad++; $display("FAIL sweep_p1 reg=%0d got=%h exp=%h", 30 - i, a1, 64'(30 - i) * 64'h0101_0101);
            end
            total++;
            if (b0 !== 64'(i) * 64'h0101_0101) begin
                bad++; $display("FAIL sweep_b reg=%0d got=%h exp=%h", i, b0, 64'(i) * 64'h0101_0101);
            end
        end
        rd_addr = {5'd31, 5'd31};
        #1;
        total++; if (a0 !== 64'h0) begin bad++; $display("FAIL sweep_r31_p0 got=%h exp=0", a0); end
        total++; if (a1 !== 64'h0) begin bad++; $display("FAIL sweep_r31_p1 got=%h exp=0", a1); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1; rd_addr = {5'd31, 5'd31};
        #1;
        total++; if (a0 !== 64'h0) begin bad++; $display("FAIL zero_byp_p0 got=%h exp=0", a0); end
        total++; if (a1 !== 64'h0) begin bad++; $display("FAIL zero_byp_p1 got=%h exp=0", a1); end
        @(negedge clk); wr_en = 1'b0; #1;
        total++; if (a0 !== 64'h0) begin bad++; $display("FAIL zero_rd got=%h exp=0", a0); end
        total++; if (b0 !== 64'h0) begin bad++; $display("FAIL zero_rd_b got=%h exp=0", b0); end
        total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL zero_ack got=%b exp=0", ack_a); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
        @(negedge clk);
        wr_data = 64'h1234; rd_addr = {5'd8, 5'd7};
        #1;
        total++; if (a0 !== 64'h1234) begin bad++; $display("FAIL byp_hit got=%h exp=1234", a0); end
        total++; if (a1 !== 64'h0808_0808) begin bad++; $display("FAIL byp_other got=%h exp=08080808", a1); end
        total++; if (b0 !== 64'h55) begin bad++; $display("FAIL nobyp_old got=%h exp=55", b0); end
        rd_addr = {5'd7, 5'd7};
        #1;
        total++; if (a1 !== 64'h1234) begin bad++; $display("FAIL byp_p1 got=%h exp=1234", a1); end
        @(negedge clk); wr_en = 1'b0; #1;
        total++; if (b0 !== 64'h1234) begin bad++; $display("FAIL nobyp_new got=%h exp=1234", b0); end
        total++; if (a0 !== a1 || a0 !== 64'h1234) begin bad++; $display("FAIL same_addr got=%h/%h exp=1234", a0, a1); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hA; rd_addr = {5'd5, 5'd5};
        @(negedge clk); wr_data = 64'hB; #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b exp=1", ack_a); end
        total++; if (b0 !== 64'hA) begin bad++; $display("FAIL b2b_a got=%h exp=a", b0); end
        @(negedge clk); wr_data = 64'hC; #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%b exp=1", ack_a); end
        total++; if (b0 !== 64'hB) begin bad++; $display("FAIL b2b_b got=%h exp=b", b0); end
        @(negedge clk); wr_en = 1'b0; #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL b2b_ack3 got=%b exp=1", ack_a); end
        total++; if (a1 !== 64'hC) begin bad++; $display("FAIL b2b_c got=%h exp=c", a1); end
        @(negedge clk); #1;
        total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL b2b_ack_end got=%b exp=0", ack_a); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h999; rd_addr = {5'd9, 5'd1};
        #1;
        total++; if (a0 !== 64'h0101_0101) begin bad++; $display("FAIL ar_pre got=%h exp=01010101", a0); end
        total++; if (a1 !== 64'h999) begin bad++; $display("FAIL ar_pre_byp got=%h exp=999", a1); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (a0 !== 64'h0) begin bad++; $display("FAIL ar_clear got=%h exp=0", a0); end
        total++; if (a1 !== 64'h0) begin bad++; $display("FAIL ar_byp_off got=%h exp=0", a1); end
        total++; if (b1 !== 64'h0) begin bad++; $display("FAIL ar_clear_b got=%h exp=0", b1); end
        @(negedge clk); #1;
        total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL ar_ack got=%b exp=0", ack_a); end
        wr_en = 1'b0; reset_n = 1'b1;
        #1;
        total++; if (b1 !== 64'h0) begin bad++; $display("FAIL ar_no_commit got=%h exp=0", b1); end
        total++; if (ack_b !== 1'b0) begin bad++; $display("FAIL ar_ack_b got=%b exp=0", ack_b); end
    endtask

    task automatic test_variant();
        @(negedge clk); v_wr_en = 1'b1; v_wr_addr = 3'd0; v_wr_data = 16'h1111;
        @(negedge clk); v_wr_addr = 3'd4; v_wr_data = 16'h4444;
        @(negedge clk); v_wr_addr = 3'd7; v_wr_data = 16'hBEEF;
        @(negedge clk); v_wr_en = 1'b0;
        v_rd_addr = {3'd7, 3'd4, 3'd0};
        #1;
        total++; if (v_ack !== 1'b1) begin bad++; $display("FAIL var_ack7 got=%b exp=1", v_ack); end
        total++; if (v_rd_data[15:0] !== 16'h1111) begin bad++; $display("FAIL var_p0 got=%h exp=1111", v_rd_data[15:0]); end
        total++; if (v_rd_data[31:16] !== 16'h4444) begin bad++; $display("FAIL var_p1 got=%h exp=4444", v_rd_data[31:16]); end
        total++; if (v_rd_data[47:32] !== 16'hBEEF) begin bad++; $display("FAIL var_p2 got=%h exp=beef", v_rd_data[47:32]); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_async_reset();
        test_variant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule
